// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, drives imem, presents (pc, inst) pairs to decode one cycle after address issue.
// A stall re-issues the held response address so imem keeps returning the same word; a redirect kills the current response.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    output logic [31:0] fetch_cnt
);
    localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + 33'(4 * IMEM_DEPTH);

    logic [31:0] r_pc_q;
    logic [31:0] r_resp_pc;
    logic [31:0] r_fetch_cnt;
    logic        r_resp_valid;

    logic        w_stall;
    logic        w_fire;
    logic        w_fault;

    assign w_stall = r_resp_valid & ~out_ready;
    assign w_fire  = out_valid & out_ready;
    // 33-bit compare so a window ending at 2^32 still works
    assign w_fault = (r_resp_pc[1:0] != 2'b00) || (r_resp_pc < RESET_PC) ||
                     ({1'b0, r_resp_pc} >= WIN_END);

    always_comb begin
        if (rst)
            imem_addr = RESET_PC;
        else if (redirect_valid)
            imem_addr = redirect_pc;
        else if (w_stall)
            imem_addr = r_resp_pc;
        else
            imem_addr = r_pc_q;
    end

    assign out_valid = ~rst & r_resp_valid & ~redirect_valid;
    assign out_pc    = r_resp_pc;
    assign out_fault = w_fault;
    assign out_inst  = w_fault ? NOP_INST : imem_data;
    assign fetch_cnt = r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q       <= RESET_PC;
            r_resp_pc    <= RESET_PC;
            r_resp_valid <= 1'b0;
            r_fetch_cnt  <= 32'd0;
        end else begin
            if (w_fire)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (redirect_valid) begin
                r_resp_pc    <= redirect_pc;
                r_resp_valid <= 1'b1;
                r_pc_q       <= redirect_pc + 32'd4;
            end else if (!w_stall) begin
                r_resp_pc    <= r_pc_q;
                r_resp_valid <= 1'b1;
                r_pc_q       <= r_pc_q + 32'd4;
            end
        end
    end
endmodule
